// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR coefficient controller.
// Coefficients are Q2.13: unity gain is 1 << COEFF_SCALE_SHIFT.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    FLUSH  = 2'd1,
    RUN    = 2'd2
  } state_e;

  localparam int          NUM_TAPS          = 8;
  localparam int          COEFF_W           = 16;
  localparam int          COEFF_SCALE_SHIFT = 13;
  localparam logic [3:0]  ADDR_STATUS       = 4'd8;
  localparam logic [15:0] COEFF_UNITY       = 16'(1) << COEFF_SCALE_SHIFT;

  typedef logic [NUM_TAPS-1:0][COEFF_W-1:0] coeff_arr_t;

  // Tap 0 at unity, all others zero: a pure passthrough filter.
  localparam coeff_arr_t COEFF_RESET = {{(NUM_TAPS-1){16'h0000}}, COEFF_UNITY};

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow and active coefficient banks. A write landing in the same cycle
// as a commit is forwarded straight into the active bank.
module fir_coeff_bank
  import fir_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [15:0] wdata_i,
  input  logic        commit_i,
  output coeff_arr_t  shadow_nxt_o,
  output coeff_arr_t  active_o,
  output logic        dirty_o
);

  coeff_arr_t shadow_q, shadow_d, active_q;
  logic       dirty_q, dirty_d;
  logic       wr_hit;

  assign wr_hit = we_i && (addr_i < ADDR_STATUS);

  always_comb begin
    shadow_d = shadow_q;
    if (wr_hit) shadow_d[addr_i[2:0]] = wdata_i;
    dirty_d = commit_i ? 1'b0 : (wr_hit ? 1'b1 : dirty_q);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shadow_q <= COEFF_RESET;
      active_q <= COEFF_RESET;
      dirty_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      if (commit_i) active_q <= shadow_d;
      dirty_q <= dirty_d;
    end
  end

  assign shadow_nxt_o = shadow_d;
  assign active_o     = active_q;
  assign dirty_o      = dirty_q;

endmodule

// File: rtl/fir_coeff_ctrl.sv
// FIR coefficient controller: register file, atomic commit and a bypass
// sequencer that holds the datapath off until its pipeline has flushed.
//
// state  | meaning
// BYPASS | filter off, waiting for fir_on_i
// FLUSH  | filter held in bypass while cnt_q counts down to 0
// RUN    | filter enabled with the active coefficients
module fir_coeff_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 12
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        reg_we_i,
  input  logic [3:0]  reg_addr_i,
  input  logic [15:0] reg_wdata_i,
  output logic [15:0] reg_rdata_o,
  input  logic        commit_i,
  input  logic        fir_on_i,
  output logic        enable_fir_o,
  output logic        busy_o,
  output logic        dirty_o,
  output logic [15:0] coeff_0_o,
  output logic [15:0] coeff_1_o,
  output logic [15:0] coeff_2_o,
  output logic [15:0] coeff_3_o,
  output logic [15:0] coeff_4_o,
  output logic [15:0] coeff_5_o,
  output logic [15:0] coeff_6_o,
  output logic [15:0] coeff_7_o
);

  localparam logic [7:0] CNT_LOAD = 8'(FLUSH_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        enable_q, busy_q;
  logic [15:0] rdata_q, rdata_d;
  coeff_arr_t  shadow_nxt, active;
  logic        dirty;

  fir_coeff_bank u_bank (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .we_i         (reg_we_i),
    .addr_i       (reg_addr_i),
    .wdata_i      (reg_wdata_i),
    .commit_i     (commit_i),
    .shadow_nxt_o (shadow_nxt),
    .active_o     (active),
    .dirty_o      (dirty)
  );

  // Dropping fir_on_i wins over everything, including a pending commit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= BYPASS;
      cnt_q    <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
    end else if (!fir_on_i) begin
      state_q  <= BYPASS;
      cnt_q    <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        BYPASS: begin
          state_q  <= FLUSH;
          cnt_q    <= CNT_LOAD;
          enable_q <= 1'b0;
          busy_q   <= 1'b1;
        end
        FLUSH: begin
          if (commit_i) begin
            cnt_q <= CNT_LOAD;
          end else if (cnt_q == '0) begin
            state_q  <= RUN;
            enable_q <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        RUN: begin
          if (commit_i) begin
            state_q  <= FLUSH;
            cnt_q    <= CNT_LOAD;
            enable_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        default: begin
          state_q  <= BYPASS;
          cnt_q    <= '0;
          enable_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  // Reading from the bank's next-state value returns same-cycle writes.
  always_comb begin
    rdata_d = '0;
    if (reg_addr_i < ADDR_STATUS) rdata_d = shadow_nxt[reg_addr_i[2:0]];
    else if (reg_addr_i == ADDR_STATUS) rdata_d = {13'b0, dirty, state_q};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign reg_rdata_o  = rdata_q;
  assign enable_fir_o = enable_q;
  assign busy_o       = busy_q;
  assign dirty_o      = dirty;
  assign coeff_0_o    = active[0];
  assign coeff_1_o    = active[1];
  assign coeff_2_o    = active[2];
  assign coeff_3_o    = active[3];
  assign coeff_4_o    = active[4];
  assign coeff_5_o    = active[5];
  assign coeff_6_o    = active[6];
  assign coeff_7_o    = active[7];

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Self-checking bench for fir_coeff_ctrl: per-cycle behavioural model plus
// directed vectors with hand-computed expectations.
module tb_fir_coeff_ctrl;

  localparam int FC = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_we = 1'b0;
  logic [3:0]  reg_addr = 4'd0;
  logic [15:0] reg_wdata = 16'h0;
  logic        commit = 1'b0;
  logic        fir_on = 1'b0;
  logic [15:0] reg_rdata;
  logic        enable_fir, busy, dirty;
  logic [15:0] coeff_o [8];

  fir_coeff_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .reg_we_i     (reg_we),
    .reg_addr_i   (reg_addr),
    .reg_wdata_i  (reg_wdata),
    .reg_rdata_o  (reg_rdata),
    .commit_i     (commit),
    .fir_on_i     (fir_on),
    .enable_fir_o (enable_fir),
    .busy_o       (busy),
    .dirty_o      (dirty),
    .coeff_0_o    (coeff_o[0]),
    .coeff_1_o    (coeff_o[1]),
    .coeff_2_o    (coeff_o[2]),
    .coeff_3_o    (coeff_o[3]),
    .coeff_4_o    (coeff_o[4]),
    .coeff_5_o    (coeff_o[5]),
    .coeff_6_o    (coeff_o[6]),
    .coeff_7_o    (coeff_o[7])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: banks as plain arrays; enable/busy derived from "edge index of the
  // last disturbance" (FIR_ON rise, or commit while on) and an unbroken FIR_ON run.
  logic [15:0] m_shadow [8];
  logic [15:0] m_active [8];
  logic        m_dirty, m_on_prev, m_on_run, m_busy, m_en;
  logic [15:0] m_rdata;
  logic [1:0]  m_st_old;
  int          m_edge, m_disturb;
  bit          cmp_en = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 8; i++) begin
          m_shadow[i] = (i == 0) ? 16'h2000 : 16'h0000;
          m_active[i] = m_shadow[i];
        end
        m_dirty = 1'b0; m_on_prev = 1'b0; m_on_run = 1'b0;
        m_busy = 1'b0; m_en = 1'b0; m_rdata = 16'h0;
        m_edge = 0; m_disturb = 0;
      end else begin
        m_st_old = m_en ? 2'd2 : (m_busy ? 2'd1 : 2'd0);
        if (reg_we && reg_addr < 4'd8) m_shadow[reg_addr[2:0]] = reg_wdata;
        if (reg_addr < 4'd8)       m_rdata = m_shadow[reg_addr[2:0]];
        else if (reg_addr == 4'd8) m_rdata = {13'b0, m_dirty, m_st_old};
        else                       m_rdata = 16'h0;
        if (commit) begin
          for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
          m_dirty = 1'b0;
        end else if (reg_we && reg_addr < 4'd8) begin
          m_dirty = 1'b1;
        end
        if (fir_on) begin
          if (!m_on_prev || commit) m_disturb = m_edge;
          m_on_run = 1'b1;
        end else begin
          m_on_run = 1'b0;
        end
        m_on_prev = fir_on;
        m_busy = m_on_run && (m_edge + 1 <= m_disturb + FC);
        m_en   = m_on_run && !m_busy;
        m_edge++;
      end
      #1;
      if (cmp_en) begin
        for (int i = 0; i < 8; i++) check($sformatf("cmp_coeff%0d", i), coeff_o[i], m_active[i]);
        check("cmp_enable", 16'(enable_fir), 16'(m_en));
        check("cmp_busy", 16'(busy), 16'(m_busy));
        check("cmp_dirty", 16'(dirty), 16'(m_dirty));
        check("cmp_rdata", reg_rdata, m_rdata);
      end
    end
  end

  logic [15:0] exp_rd [9] = '{16'h2000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Reset readback of all shadow entries and status.
    for (int a = 0; a < 9; a++) begin
      @(negedge clk); reg_addr = 4'(a);
      @(posedge clk); #1;
      check($sformatf("rst_read%0d", a), reg_rdata, exp_rd[a]);
    end
    check("rst_coeff0", coeff_o[0], 16'h2000);
    check("rst_enable", 16'(enable_fir), 16'h0);

    // Write then commit.
    @(negedge clk); reg_we = 1'b1; reg_addr = 4'd3; reg_wdata = 16'h1234;
    @(negedge clk); reg_we = 1'b0; reg_addr = 4'd8;
    check("wr_dirty", 16'(dirty), 16'h1);
    check("wr_coeff3_old", coeff_o[3], 16'h0000);
    @(posedge clk); #1;
    check("status_dirty", reg_rdata, 16'h0004);
    @(negedge clk); commit = 1'b1;
    @(posedge clk); #1;
    check("commit_coeff3", coeff_o[3], 16'h1234);
    check("commit_dirty", 16'(dirty), 16'h0);

    // Status-range write is ignored; read back addr 3.
    @(negedge clk); commit = 1'b0; reg_we = 1'b1; reg_addr = 4'd9; reg_wdata = 16'hABCD;
    @(negedge clk); reg_we = 1'b0; reg_addr = 4'd3;
    check("hiaddr_dirty", 16'(dirty), 16'h0);
    @(posedge clk); #1;
    check("read3", reg_rdata, 16'h1234);

    // Same-cycle write and read.
    @(negedge clk); reg_we = 1'b1; reg_addr = 4'd5; reg_wdata = 16'h5555;
    @(posedge clk); #1;
    check("wr_rd_fwd", reg_rdata, 16'h5555);
    @(negedge clk); reg_we = 1'b0; reg_addr = 4'd12;
    @(posedge clk); #1;
    check("read12", reg_rdata, 16'h0000);

    // FIR_ON rise: busy for FC cycles, then enabled.
    @(negedge clk); fir_on = 1'b1;
    for (int i = 1; i <= FC + 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("on_busy%0d", i), 16'(busy), 16'(i <= FC));
      check($sformatf("on_en%0d", i), 16'(enable_fir), 16'(i > FC));
    end
    @(negedge clk); reg_addr = 4'd8;
    @(posedge clk); #1;
    check("status_run", reg_rdata, 16'h0006);

    // Commit in RUN, then a second commit five cycles later extends the flush.
    for (int i = 0; i <= FC + 8; i++) begin
      @(negedge clk); commit = (i == 0 || i == 5);
      @(posedge clk); #1;
      check($sformatf("recommit_en%0d", i), 16'(enable_fir), 16'(i >= 5 + FC));
    end

    // Forwarded write with commit, then drop FIR_ON mid-flush.
    @(negedge clk); commit = 1'b1; reg_we = 1'b1; reg_addr = 4'd7; reg_wdata = 16'hFFFF;
    @(posedge clk); #1;
    check("fwd_coeff7", coeff_o[7], 16'hFFFF);
    check("fwd_dirty", 16'(dirty), 16'h0);
    check("fwd_busy", 16'(busy), 16'h1);
    @(negedge clk); commit = 1'b0; reg_we = 1'b0;
    repeat (3) @(negedge clk);
    fir_on = 1'b0;
    @(posedge clk); #1;
    check("off_busy", 16'(busy), 16'h0);
    check("off_en", 16'(enable_fir), 16'h0);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-flush.
    fir_on = 1'b1; reg_we = 1'b1; reg_addr = 4'd1; reg_wdata = 16'h4321;
    @(negedge clk); reg_we = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) check($sformatf("arst_coeff%0d", i), coeff_o[i], exp_rd[i]);
    check("arst_busy", 16'(busy), 16'h0);
    check("arst_en", 16'(enable_fir), 16'h0);
    check("arst_dirty", 16'(dirty), 16'h0);
    check("arst_rdata", reg_rdata, 16'h0000);
    fir_on = 1'b0;
    @(negedge clk); rst_n = 1'b1; reg_addr = 4'd8;
    @(posedge clk); #1;
    check("arst_status", reg_rdata, 16'h0000);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
